// File: rtl/weight_seq_if.sv
// Handshake bundle between the weight sequencer, input stream,
// weight memory and downstream MAC.
interface weight_seq_if #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 16
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     x_valid;
  logic                     x_ready;
  logic [DATA_WIDTH-1:0]    x_data;
  logic                     r_en;
  logic [ADDRESS_WIDTH-1:0] r_add;
  logic [DATA_WIDTH-1:0]    w_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_x;
  logic [DATA_WIDTH-1:0]    out_w;
  logic                     out_last;

  modport master (
    input  start,
    output busy,
    output done,
    input  x_valid,
    output x_ready,
    input  x_data,
    output r_en,
    output r_add,
    input  w_in,
    output out_valid,
    input  out_ready,
    output out_x,
    output out_w,
    output out_last
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    output x_valid,
    input  x_ready,
    output x_data,
    input  r_en,
    input  r_add,
    output w_in,
    input  out_valid,
    output out_ready,
    input  out_x,
    input  out_w,
    input  out_last
  );
endinterface

// File: rtl/weight_seq_ctrl.sv
// Pairs each accepted input sample with its weight read from a
// one-cycle-latency memory and streams the pairs to a MAC.
module weight_seq_ctrl #(
  parameter int NUM_WEIGHT    = 3,
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 16
) (
  input logic          clk,
  input logic          rst_n,
  weight_seq_if.master bus
);
  // One spare bit so idx can reach NUM_WEIGHT without wrapping.
  localparam int IW = ADDRESS_WIDTH + 1;
  localparam logic [IW-1:0] NUM = IW'(NUM_WEIGHT);
  localparam logic [IW-1:0] LAST = IW'(NUM_WEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [IW-1:0]         idx;
  logic                  pend_valid;
  logic                  pend_last;
  logic [DATA_WIDTH-1:0] pend_x;
  logic                  ov;
  logic                  ol;
  logic [DATA_WIDTH-1:0] ox;
  logic [DATA_WIDTH-1:0] ow;
  logic                  pend_move;
  logic                  x_rdy;
  logic                  accept;
  logic                  done_c;

  always_comb begin
    pend_move = pend_valid && (!ov || bus.out_ready);
    x_rdy     = (state == RUN) && (idx < NUM)
             && (!pend_valid || pend_move);
    accept    = bus.x_valid && x_rdy;
    done_c    = (state == DRAIN) && ov
             && bus.out_ready && ol;
    state_nx  = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = RUN;
      RUN:   if (accept && idx == LAST) state_nx = DRAIN;
      DRAIN: if (done_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) idx <= '0;
      else if (accept) idx <= idx + IW'(1);
    end
  end

  // Pending slot holds the sample while its weight is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      pend_x     <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_x     <= bus.x_data;
      pend_last  <= (idx == LAST);
    end else if (pend_move) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov <= 1'b0;
      ol <= 1'b0;
      ox <= '0;
      ow <= '0;
    end else if (pend_move) begin
      ov <= 1'b1;
      ol <= pend_last;
      ox <= pend_x;
      ow <= bus.w_in;
    end else if (bus.out_ready) begin
      ov <= 1'b0;
      ol <= 1'b0;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_c;
  assign bus.x_ready   = x_rdy;
  assign bus.r_en      = accept;
  assign bus.r_add     = idx[ADDRESS_WIDTH-1:0];
  assign bus.out_valid = ov;
  assign bus.out_last  = ol;
  assign bus.out_x     = ox;
  assign bus.out_w     = ow;
endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed bench for weight_seq_ctrl with a registered weight
// memory model; expected values are hand-computed per cycle.
module tb_weight_seq_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] mem [4];

  weight_seq_if #(.ADDRESS_WIDTH(2), .DATA_WIDTH(16)) bus ();

  weight_seq_ctrl #(
    .NUM_WEIGHT(3),
    .ADDRESS_WIDTH(2),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.r_en) bus.w_in <= mem[bus.r_add];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic full_pass(input logic [15:0] a,
                           input logic [15:0] b,
                           input logic [15:0] c);
    @(negedge clk);
    bus.start = 1; bus.x_valid = 0; bus.out_ready = 1;
    #1 chk("fp_idle_busy", bus.busy, 0);
    chk("fp_idle_xrdy", bus.x_ready, 0);
    @(negedge clk);
    bus.start = 0; bus.x_valid = 1; bus.x_data = a;
    #1 chk("fp_c1_busy", bus.busy, 1);
    chk("fp_c1_ren", bus.r_en, 1);
    chk("fp_c1_radd", bus.r_add, 0);
    @(negedge clk);
    bus.x_data = b;
    #1 chk("fp_c2_ren", bus.r_en, 1);
    chk("fp_c2_radd", bus.r_add, 1);
    chk("fp_c2_ov", bus.out_valid, 0);
    @(negedge clk);
    bus.x_data = c;
    #1 chk("fp_c3_radd", bus.r_add, 2);
    chk("fp_c3_ren", bus.r_en, 1);
    chk("fp_c3_ov", bus.out_valid, 1);
    chk("fp_c3_x", bus.out_x, a);
    chk("fp_c3_w", bus.out_w, 16'h0011);
    chk("fp_c3_last", bus.out_last, 0);
    @(negedge clk);
    bus.x_valid = 0;
    #1 chk("fp_c4_xrdy", bus.x_ready, 0);
    chk("fp_c4_ren", bus.r_en, 0);
    chk("fp_c4_x", bus.out_x, b);
    chk("fp_c4_w", bus.out_w, 16'h0022);
    chk("fp_c4_last", bus.out_last, 0);
    chk("fp_c4_done", bus.done, 0);
    @(negedge clk);
    #1 chk("fp_c5_x", bus.out_x, c);
    chk("fp_c5_w", bus.out_w, 16'h0033);
    chk("fp_c5_last", bus.out_last, 1);
    chk("fp_c5_done", bus.done, 1);
    @(negedge clk);
    #1 chk("fp_c6_busy", bus.busy, 0);
    chk("fp_c6_done", bus.done, 0);
    chk("fp_c6_ov", bus.out_valid, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem[0] = 16'h0011; mem[1] = 16'h0022;
    mem[2] = 16'h0033; mem[3] = 16'h0044;
    bus.w_in = 0;
    bus.start = 0; bus.x_valid = 0;
    bus.x_data = 0; bus.out_ready = 1;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_busy", bus.busy, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_xrdy", bus.x_ready, 0);
    chk("rst_radd", bus.r_add, 0);
    chk("rst_outx", bus.out_x, 0);
    rst_n = 1;

    // basic pass
    full_pass(16'd1, 16'd2, 16'd3);

    // backpressure pass, start coincident with done
    @(negedge clk);
    bus.start = 1; bus.x_valid = 1; bus.x_data = 4;
    #1 chk("bp_idle_ren", bus.r_en, 0);
    @(negedge clk);
    bus.start = 0;
    #1 chk("bp_a0_radd", bus.r_add, 0);
    chk("bp_a0_ren", bus.r_en, 1);
    @(negedge clk);
    bus.x_data = 5;
    #1 chk("bp_a1_radd", bus.r_add, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.out_ready = 0; bus.x_data = 6;
      #1 chk("bp_hold_ov", bus.out_valid, 1);
      chk("bp_hold_x", bus.out_x, 4);
      chk("bp_hold_w", bus.out_w, 16'h0011);
      chk("bp_hold_xrdy", bus.x_ready, 0);
      chk("bp_hold_ren", bus.r_en, 0);
      chk("bp_hold_radd", bus.r_add, 2);
    end
    @(negedge clk);
    bus.out_ready = 1;
    #1 chk("bp_rel_x", bus.out_x, 4);
    chk("bp_rel_xrdy", bus.x_ready, 1);
    chk("bp_rel_radd", bus.r_add, 2);
    @(negedge clk);
    bus.x_valid = 0;
    #1 chk("bp_p2_x", bus.out_x, 5);
    chk("bp_p2_w", bus.out_w, 16'h0022);
    chk("bp_p2_last", bus.out_last, 0);
    @(negedge clk);
    bus.start = 1;
    #1 chk("bp_p3_x", bus.out_x, 6);
    chk("bp_p3_w", bus.out_w, 16'h0033);
    chk("bp_p3_last", bus.out_last, 1);
    chk("bp_p3_done", bus.done, 1);
    @(negedge clk);
    bus.start = 0;
    #1 chk("bp_after_busy", bus.busy, 0);
    @(negedge clk);
    #1 chk("bp_nopass_busy", bus.busy, 0);

    // toggled x_valid, start while busy
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0; bus.x_valid = 1; bus.x_data = 7;
    #1 chk("tg_c1_ren", bus.r_en, 1);
    chk("tg_c1_radd", bus.r_add, 0);
    @(negedge clk);
    bus.x_valid = 0; bus.start = 1;
    #1 chk("tg_c2_ren", bus.r_en, 0);
    chk("tg_c2_xrdy", bus.x_ready, 1);
    chk("tg_c2_radd", bus.r_add, 1);
    @(negedge clk);
    bus.x_valid = 1; bus.x_data = 8; bus.start = 0;
    #1 chk("tg_c3_ren", bus.r_en, 1);
    chk("tg_c3_radd", bus.r_add, 1);
    chk("tg_c3_x", bus.out_x, 7);
    chk("tg_c3_w", bus.out_w, 16'h0011);
    @(negedge clk);
    bus.x_valid = 0;
    #1 chk("tg_c4_ren", bus.r_en, 0);
    chk("tg_c4_ov", bus.out_valid, 0);
    chk("tg_c4_radd", bus.r_add, 2);
    @(negedge clk);
    bus.x_valid = 1; bus.x_data = 9;
    #1 chk("tg_c5_x", bus.out_x, 8);
    chk("tg_c5_w", bus.out_w, 16'h0022);
    chk("tg_c5_radd", bus.r_add, 2);
    chk("tg_c5_ren", bus.r_en, 1);
    @(negedge clk);
    bus.x_valid = 0;
    #1 chk("tg_c6_ov", bus.out_valid, 0);
    chk("tg_c6_done", bus.done, 0);
    @(negedge clk);
    #1 chk("tg_c7_x", bus.out_x, 9);
    chk("tg_c7_w", bus.out_w, 16'h0033);
    chk("tg_c7_done", bus.done, 1);
    @(negedge clk);
    #1 chk("tg_c8_busy", bus.busy, 0);

    // reset after the second accept
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0; bus.x_valid = 1; bus.x_data = 1;
    @(negedge clk);
    bus.x_data = 2;
    @(negedge clk);
    bus.x_valid = 0; rst_n = 0;
    #1 chk("mr_ov", bus.out_valid, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_outx", bus.out_x, 0);
    chk("mr_outw", bus.out_w, 0);
    chk("mr_radd", bus.r_add, 0);
    chk("mr_xrdy", bus.x_ready, 0);
    chk("mr_ren", bus.r_en, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_last", bus.out_last, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1 chk("mr_wait_busy", bus.busy, 0);
    chk("mr_wait_ov", bus.out_valid, 0);

    // two back-to-back passes after reset
    full_pass(16'h000A, 16'h000B, 16'h000C);
    full_pass(16'h1234, 16'hBEEF, 16'h00FF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_seq_ctrl.md
WEIGHT_SEQ_CTRL -- requirements
Module: weight_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_WEIGHT, default 3, number of weights (and inputs) per neuron pass.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 2, width of r_add; SHALL satisfy 2^ADDRESS_WIDTH >= NUM_WEIGHT.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, width of input and weight words.
REQ-004 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port start  input  1  one-cycle request to begin a pass.
REQ-007 The block SHALL have port busy  output  1  high while a pass is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse when a pass completes.
REQ-009 The block SHALL have port x_valid  input  1  input sample valid.
REQ-010 The block SHALL have port x_ready  output  1  input sample accepted when high with x_valid.
REQ-011 The block SHALL have port x_data  input  DATA_WIDTH  input sample.
REQ-012 The block SHALL have port r_en  output  1  weight memory read enable.
REQ-013 The block SHALL have port r_add  output  ADDRESS_WIDTH  weight memory read address.
REQ-014 The block SHALL have port w_in  input  DATA_WIDTH  weight memory read data.
REQ-015 The block SHALL have port out_valid  output  1  paired sample/weight valid.
REQ-016 The block SHALL have port out_ready  input  1  downstream (MAC) accepts pair.
REQ-017 The block SHALL have port out_x  output  DATA_WIDTH  paired input sample.
REQ-018 The block SHALL have port out_w  output  DATA_WIDTH  paired weight.
REQ-019 The block SHALL have port out_last  output  1  marks pair with index NUM_WEIGHT-1.

Function
REQ-020 Memory contract: w_in valid the cycle after r_en=1 with r_add; w_in stable while r_en=0.
REQ-021 FSM states IDLE, RUN, DRAIN; busy = (state != IDLE).
REQ-022 IDLE -> RUN on start=1; index counter cleared to 0; start ignored outside IDLE.
REQ-023 x_ready = (state==RUN) && (idx < NUM_WEIGHT) && (!pend_valid || pend_move), where pend_move = pend_valid && (!out_valid || out_ready).
REQ-024 Accept (x_valid && x_ready) in cycle t: r_en=1, r_add=idx combinationally in t; at edge: pend_valid<=1, pend_x<=x_data, pend_last<=(idx==NUM_WEIGHT-1), idx<=idx+1.
REQ-025 r_en SHALL be 1 only in accept cycles; r_add SHALL equal idx at all times.
REQ-026 On pend_move: out_x<=pend_x, out_w<=w_in, out_last<=pend_last, out_valid<=1; pend_valid cleared unless a new accept occurs the same cycle.
REQ-027 out_valid cleared when out_ready=1 and no pend_move that cycle; outputs held stable while out_valid=1 and out_ready=0.
REQ-028 Latency accept -> out_valid SHALL be 2 cycles with no backpressure; throughput 1 pair/cycle.
REQ-029 RUN -> DRAIN after the accept with idx==NUM_WEIGHT-1.
REQ-030 DRAIN -> IDLE on the cycle out_valid && out_ready && out_last; done=1 that cycle (combinational pulse, one cycle).
REQ-031 start coincident with done SHALL be ignored; next pass requires start in IDLE.
REQ-032 x_data values presented while x_ready=0 SHALL be ignored; no address skip or repeat within a pass.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, pend_valid=0, out_valid=0, out_last=0, out_x=0, out_w=0, busy=0, done=0, x_ready=0, r_en=0, r_add=0.
REQ-034 Reset mid-pass SHALL discard all in-flight pairs; after release the block waits in IDLE for start.

Verification
REQ-035 Weights {0x0011,0x0022,0x0033}, start, x_valid=1 x={1,2,3}, out_ready=1 -> r_add 0,1,2 consecutive; pairs (1,0x0011),(2,0x0022),(3,0x0033) at accept+2; out_last on third; done one cycle; busy low after.
REQ-036 Same pass with out_ready=0 for 4 cycles after first out_valid -> x_ready drops after 2 accepts; out_x/out_w held; no pair lost/duplicated after release.
REQ-037 x_valid toggled 1,0,1,0,1 -> r_en only on accept cycles, addresses 0,1,2 in order, done after third pair.
REQ-038 start asserted while busy and start coincident with done -> ignored; idx not reset; no second pass.
REQ-039 rst_n low after second accept -> all outputs 0 immediately; after release, new start yields full 3-pair pass from address 0.
REQ-040 Two back-to-back passes -> second pass addresses restart at 0; out_last exactly once per pass.
